// File: rtl/encode_align_ctrl.sv
// -----------------------------------------------------------------------------
// encode_align_ctrl
//
// Sequencer for the encoder-alignment datapath. It checks a signed align offset
// and applies it. It pulses the align FIFO reset, waits for the datapath to
// settle, and then gates scan_en into the datapath for each scan request. While
// scanning it counts aligned encoder samples. A scan stops when the sample
// length is reached, when the request drops, or when the watchdog expires. After
// every stop the block re-aligns automatically with the same offset.
//
// Parameters
//   FIFO_DEPTH   align FIFO depth; the most negative legal offset is -(FIFO_DEPTH-1)
//   RST_CYC      cycles align_rst_o is held high per reset sequence (>=1)
//   SETTLE_CYC   cycles waited after align_rst_o falls before ARMED (>=1)
//   TIMEOUT_CYC  SCAN cycles without encode_en_i before a timeout stop; 0 disables it
//
// Ports
//   clk_i            in   system clock
//   rst_n_i          in   asynchronous active-low reset
//   cfg_wr_i         in   one-cycle strobe: new offset on cfg_align_set_i
//   cfg_align_set_i  in   signed offset (>=0 delay, <0 prefill depth)
//   scan_req_i       in   level scan request
//   scan_len_i       in   samples per scan, latched on SCAN entry; 0 = unlimited
//   encode_en_i      in   aligned sample valid from the datapath
//   err_clr_i        in   clears the sticky error flags
//   align_rst_o      out  align FIFO/datapath reset
//   align_set_o      out  applied offset
//   scan_en_o        out  scan enable to the datapath
//   ready_o          out  high in ARMED
//   busy_o           out  high in RST, SETTLE, SCAN, STOP
//   done_o           out  one-cycle pulse on STOP entry
//   stop_reason_o    out  last stop cause: 0 none, 1 req drop, 2 length, 3 timeout
//   sample_cnt_o     out  samples in the current/last scan, saturating
//   cfg_err_o        out  sticky: offset write rejected
//   timeout_err_o    out  sticky: watchdog expired
// -----------------------------------------------------------------------------
module encode_align_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 8192,
  parameter int unsigned RST_CYC     = 4,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cfg_wr_i,
  input  logic [31:0] cfg_align_set_i,
  input  logic        scan_req_i,
  input  logic [31:0] scan_len_i,
  input  logic        encode_en_i,
  input  logic        err_clr_i,
  output logic        align_rst_o,
  output logic [31:0] align_set_o,
  output logic        scan_en_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  stop_reason_o,
  output logic [31:0] sample_cnt_o,
  output logic        cfg_err_o,
  output logic        timeout_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SETTLE, S_ARMED, S_SCAN, S_STOP
  } state_t;

  localparam logic [1:0] STOP_NONE    = 2'd0;
  localparam logic [1:0] STOP_DROP    = 2'd1;
  localparam logic [1:0] STOP_LEN     = 2'd2;
  localparam logic [1:0] STOP_TIMEOUT = 2'd3;

  // One phase counter serves both RST and SETTLE. It runs 0..N-1.
  localparam int unsigned PH_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int          PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] RST_LAST    = PH_W'(RST_CYC - 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYC - 1);

  localparam logic signed [31:0] OFF_MAX = 32'sd16383;
  localparam logic signed [31:0] OFF_MIN = 32'sd1 - $signed(32'(FIFO_DEPTH));
  localparam logic [31:0]        WD_LAST = 32'(TIMEOUT_CYC - 1);

  state_t          state;
  logic [PH_W-1:0] ph_cnt;
  logic [31:0]     scan_len_q;
  logic [31:0]     wd_q;
  logic            scan_req_d;

  logic signed [31:0] off;
  logic               off_legal;
  logic [31:0]        cnt_inc;
  logic [31:0]        cnt_nxt;
  logic               hit_len;
  logic               hit_to;
  logic               cfg_open;

  assign off       = $signed(cfg_align_set_i);
  assign off_legal = off[31] ? (off >= OFF_MIN) : (off <= OFF_MAX);
  assign cfg_open  = (state == S_IDLE) || (state == S_ARMED);

  // The length check uses the count after this edge's increment. A scan of
  // length N therefore stops on the very edge that takes the Nth sample.
  assign cnt_inc = (sample_cnt_o == '1) ? sample_cnt_o : sample_cnt_o + 32'd1;
  assign cnt_nxt = encode_en_i ? cnt_inc : sample_cnt_o;
  assign hit_len = (scan_len_q != 32'd0) && (cnt_nxt == scan_len_q);
  assign hit_to  = (TIMEOUT_CYC != 0) && (wd_q == WD_LAST);

  // NOTE: every register, the config copies included, gets the asynchronous
  // reset. After reset the block sits idle and needs a fresh cfg_wr_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_IDLE;
      ph_cnt        <= '0;
      scan_len_q    <= '0;
      wd_q          <= '0;
      scan_req_d    <= 1'b0;
      align_rst_o   <= 1'b0;
      align_set_o   <= '0;
      scan_en_o     <= 1'b0;
      ready_o       <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      stop_reason_o <= STOP_NONE;
      sample_cnt_o  <= '0;
      cfg_err_o     <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, where the last one wins. A clear written
      // here is overridden by any error set later in the same cycle.
      scan_req_d <= scan_req_i;
      done_o     <= 1'b0;
      if (err_clr_i) begin
        cfg_err_o     <= 1'b0;
        timeout_err_o <= 1'b0;
      end
      if (cfg_wr_i && !cfg_open) cfg_err_o <= 1'b1;

      case (state)
        S_IDLE, S_ARMED: begin
          if (cfg_wr_i) begin
            if (off_legal) begin
              align_set_o <= cfg_align_set_i;
              align_rst_o <= 1'b1;
              ready_o     <= 1'b0;
              busy_o      <= 1'b1;
              ph_cnt      <= '0;
              state       <= S_RST;
            end else begin
              cfg_err_o <= 1'b1;
            end
          end else if (state == S_ARMED && scan_req_i && !scan_req_d) begin
            // scan_req_d follows the request in every state. A request held
            // through RST/SETTLE therefore does not count as a rising edge.
            scan_en_o     <= 1'b1;
            ready_o       <= 1'b0;
            busy_o        <= 1'b1;
            sample_cnt_o  <= '0;
            scan_len_q    <= scan_len_i;
            wd_q          <= '0;
            stop_reason_o <= STOP_NONE;
            state         <= S_SCAN;
          end
        end

        S_RST: begin
          if (ph_cnt == RST_LAST) begin
            align_rst_o <= 1'b0;
            ph_cnt      <= '0;
            state       <= S_SETTLE;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        S_SETTLE: begin
          if (ph_cnt == SETTLE_LAST) begin
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            ph_cnt  <= '0;
            state   <= S_ARMED;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        S_SCAN: begin
          sample_cnt_o <= cnt_nxt;
          wd_q         <= encode_en_i ? 32'd0 : wd_q + 32'd1;
          if (hit_len || !scan_req_i || hit_to) begin
            scan_en_o <= 1'b0;
            done_o    <= 1'b1;
            state     <= S_STOP;
            if (hit_len) begin
              stop_reason_o <= STOP_LEN;
            end else if (!scan_req_i) begin
              stop_reason_o <= STOP_DROP;
            end else begin
              stop_reason_o <= STOP_TIMEOUT;
              timeout_err_o <= 1'b1;
            end
          end
        end

        S_STOP: begin
          // Re-align automatically with the offset already applied.
          align_rst_o <= 1'b1;
          ph_cnt      <= '0;
          state       <= S_RST;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_encode_align_ctrl
//
// Self-checking bench for encode_align_ctrl. It generates random encode_en and
// scan_req patterns. It predicts the stop point, the stop cause and the sample
// count from the stop rules, and compares them with the DUT. It also checks the
// lengths of the reset and settle phases, the offset range, the sticky error
// flags and the asynchronous reset.
// -----------------------------------------------------------------------------
module tb_encode_align_ctrl;

  localparam int FIFO_DEPTH  = 8192;
  localparam int RST_CYC     = 4;
  localparam int SETTLE_CYC  = 16;
  localparam int TIMEOUT_CYC = 50;
  localparam int MAX_N       = 1100;

  logic        clk_i, rst_n_i;
  logic        cfg_wr_i;
  logic [31:0] cfg_align_set_i;
  logic        scan_req_i;
  logic [31:0] scan_len_i;
  logic        encode_en_i;
  logic        err_clr_i;
  logic        align_rst_o;
  logic [31:0] align_set_o;
  logic        scan_en_o, ready_o, busy_o, done_o;
  logic [1:0]  stop_reason_o;
  logic [31:0] sample_cnt_o;
  logic        cfg_err_o, timeout_err_o;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [31:0] cur_off;
  logic        exp_cfg_err, exp_to_err;
  bit          en_pat  [MAX_N];
  bit          req_pat [MAX_N];

  encode_align_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .RST_CYC    (RST_CYC),
    .SETTLE_CYC (SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .cfg_wr_i       (cfg_wr_i),
    .cfg_align_set_i(cfg_align_set_i),
    .scan_req_i     (scan_req_i),
    .scan_len_i     (scan_len_i),
    .encode_en_i    (encode_en_i),
    .err_clr_i      (err_clr_i),
    .align_rst_o    (align_rst_o),
    .align_set_o    (align_set_o),
    .scan_en_o      (scan_en_o),
    .ready_o        (ready_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .stop_reason_o  (stop_reason_o),
    .sample_cnt_o   (sample_cnt_o),
    .cfg_err_o      (cfg_err_o),
    .timeout_err_o  (timeout_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "bench time limit exceeded");
  end

  // Outputs are sampled 1 time unit after the edge. Inputs driven then are
  // picked up by the next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_cfg(input logic [31:0] v);
    cfg_wr_i        = 1'b1;
    cfg_align_set_i = v;
    tick();
    cfg_wr_i        = 1'b0;
  endtask

  // Behavioural prediction of one scan. Cycle i is the i-th SCAN edge. The
  // watchdog value seen at cycle i is the run of idle cycles just before it.
  task automatic model_scan(input int unsigned len, input int n,
                            output int stop_i, output int reason, output int cnt);
    int ones, idle_run;
    stop_i = -1; reason = 0; cnt = 0; ones = 0; idle_run = 0;
    for (int i = 0; i < n; i++) begin
      ones += int'(en_pat[i]);
      if (len != 0 && ones == int'(len))                reason = 2;
      else if (!req_pat[i])                             reason = 1;
      else if (TIMEOUT_CYC != 0 && idle_run == TIMEOUT_CYC - 1) reason = 3;
      if (reason != 0) begin
        stop_i = i;
        cnt    = ones;
        break;
      end
      idle_run = en_pat[i] ? 0 : idle_run + 1;
    end
  endtask

  task automatic fill_pattern(input int prob, input int drop_at);
    for (int i = 0; i < MAX_N; i++) begin
      en_pat[i]  = ($urandom_range(0, 99) < prob);
      req_pat[i] = (i < drop_at);
    end
  endtask

  // Called right after the edge on which align_rst_o rose. Measures the reset
  // and settle phases and confirms the block ends up ARMED.
  task automatic realign(input string name);
    int n, m, busy_bad;
    n = 1; m = 0; busy_bad = 0;
    while (align_rst_o === 1'b1 && n < 64) begin
      tick();
      if (align_rst_o === 1'b1) n++;
      if (busy_o !== 1'b1) busy_bad++;
    end
    chk_cnt++;
    if (n !== RST_CYC) $display("FAIL %s_rst_len: got %0d want %0d", name, n, RST_CYC);
    else pass_cnt++;
    while (ready_o !== 1'b1 && m < 64) begin
      tick();
      m++;
      if (ready_o !== 1'b1 && busy_o !== 1'b1) busy_bad++;
    end
    chk_cnt++;
    if (m !== SETTLE_CYC) $display("FAIL %s_settle_len: got %0d want %0d", name, m, SETTLE_CYC);
    else pass_cnt++;
    chk_cnt++;
    if ({ready_o, busy_o, align_rst_o, scan_en_o, align_set_o, busy_bad} !==
        {4'b1000, cur_off, 32'd0})
      $display("FAIL %s_armed: got rdy/busy/rst/en=%b%b%b%b set=%h busy_bad=%0d want 1000 set=%h 0",
               name, ready_o, busy_o, align_rst_o, scan_en_o, align_set_o, busy_bad, cur_off);
    else pass_cnt++;
  endtask

  // Runs one scan from ARMED using en_pat/req_pat. If cfg_at is in range, a
  // cfg_wr is issued on that scan cycle. hold keeps the request high after the stop.
  task automatic run_scan(input int unsigned len, input int n, input int cfg_at,
                          input bit hold, input string name);
    int exp_stop, exp_reason, exp_cnt, cyc, gap;
    bit seen;
    model_scan(len, n, exp_stop, exp_reason, exp_cnt);
    scan_len_i  = len;
    scan_req_i  = 1'b1;
    encode_en_i = 1'b1;
    tick();
    chk_cnt++;
    if ({scan_en_o, ready_o, busy_o, done_o, sample_cnt_o, stop_reason_o} !== {4'b1010, 34'd0})
      $display("FAIL %s_entry: got en/rdy/busy/done=%b%b%b%b cnt=%0d reason=%0d want 1010 0 0",
               name, scan_en_o, ready_o, busy_o, done_o, sample_cnt_o, stop_reason_o);
    else pass_cnt++;
    scan_len_i = $urandom;
    cyc = 0; gap = 0; seen = 1'b0;
    for (int i = 0; i < n && !seen; i++) begin
      encode_en_i = en_pat[i];
      scan_req_i  = req_pat[i];
      if (i == cfg_at) begin
        cfg_wr_i        = 1'b1;
        cfg_align_set_i = 32'd55;
        exp_cfg_err     = 1'b1;
      end
      tick();
      cfg_wr_i = 1'b0;
      cyc++;
      if (done_o === 1'b1) seen = 1'b1;
      else if (scan_en_o !== 1'b1) gap++;
    end
    if (exp_reason == 3) exp_to_err = 1'b1;
    chk_cnt++;
    if ({seen, cyc, gap} !== {1'b1, exp_stop + 1, 32'd0})
      $display("FAIL %s_stop_cycle: got done=%b cycles=%0d en_gaps=%0d want 1 %0d 0",
               name, seen, cyc, gap, exp_stop + 1);
    else pass_cnt++;
    chk_cnt++;
    if ({stop_reason_o, sample_cnt_o, scan_en_o} !== {2'(exp_reason), 32'(exp_cnt), 1'b0})
      $display("FAIL %s_result: got reason=%0d cnt=%0d en=%b want %0d %0d 0",
               name, stop_reason_o, sample_cnt_o, scan_en_o, exp_reason, exp_cnt);
    else pass_cnt++;
    chk_cnt++;
    if ({cfg_err_o, timeout_err_o} !== {exp_cfg_err, exp_to_err})
      $display("FAIL %s_err_flags: got %b%b want %b%b",
               name, cfg_err_o, timeout_err_o, exp_cfg_err, exp_to_err);
    else pass_cnt++;
    encode_en_i = 1'($urandom_range(0, 1));
    scan_req_i  = hold;
    tick();
    chk_cnt++;
    if ({done_o, align_rst_o, busy_o} !== 3'b011)
      $display("FAIL %s_rerst: got done/rst/busy=%b%b%b want 011", name, done_o, align_rst_o, busy_o);
    else pass_cnt++;
    realign(name);
    chk_cnt++;
    if ({stop_reason_o, sample_cnt_o} !== {2'(exp_reason), 32'(exp_cnt)})
      $display("FAIL %s_held: got reason=%0d cnt=%0d want %0d %0d",
               name, stop_reason_o, sample_cnt_o, exp_reason, exp_cnt);
    else pass_cnt++;
    encode_en_i = 1'b0;
    if (hold) begin
      repeat (5) tick();
      chk_cnt++;
      if ({ready_o, scan_en_o} !== 2'b10)
        $display("FAIL %s_no_rescan: got rdy/en=%b%b want 10", name, ready_o, scan_en_o);
      else pass_cnt++;
      scan_req_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; cfg_wr_i = 1'b0; cfg_align_set_i = '0; scan_req_i = 1'b0;
    scan_len_i = '0; encode_en_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) tick();
    chk_cnt++;
    if ({align_rst_o, align_set_o, scan_en_o, ready_o, busy_o, done_o, stop_reason_o,
         sample_cnt_o, cfg_err_o, timeout_err_o} !== 73'd0)
      $display("FAIL reset_outputs: got set=%h cnt=%h flags=%b%b%b%b%b%b%b%b%b want all 0",
               align_set_o, sample_cnt_o, align_rst_o, scan_en_o, ready_o, busy_o, done_o,
               stop_reason_o[1], stop_reason_o[0], cfg_err_o, timeout_err_o);
    else pass_cnt++;
    rst_n_i = 1'b1;
    scan_req_i = 1'b1;
    repeat (3) tick();
    chk_cnt++;
    if ({ready_o, busy_o, scan_en_o, align_rst_o} !== 4'b0000)
      $display("FAIL reset_idle: got rdy/busy/en/rst=%b%b%b%b want 0000",
               ready_o, busy_o, scan_en_o, align_rst_o);
    else pass_cnt++;
    scan_req_i = 1'b0;
    cur_off = '0; exp_cfg_err = 1'b0; exp_to_err = 1'b0;
  endtask

  task automatic test_cfg_offset();
    apply_cfg(32'd100);
    cur_off = 32'd100;
    chk_cnt++;
    if ({align_rst_o, busy_o, ready_o, align_set_o} !== {3'b110, 32'd100})
      $display("FAIL cfg100_accept: got rst/busy/rdy=%b%b%b set=%0d want 110 100",
               align_rst_o, busy_o, ready_o, align_set_o);
    else pass_cnt++;
    realign("cfg100");
  endtask

  task automatic test_scan_length();
    fill_pattern(100, MAX_N);
    run_scan(1000, MAX_N, -1, 1'b1, "len1000");
  endtask

  task automatic test_offset_range();
    logic [31:0] bad [2];
    logic [31:0] good [2];
    bad[0] = 32'hFFFF_E000; bad[1] = 32'd16384;
    good[0] = 32'd16383;    good[1] = 32'hFFFF_E001;
    for (int k = 0; k < 2; k++) begin
      apply_cfg(bad[k]);
      chk_cnt++;
      if ({cfg_err_o, ready_o, align_rst_o, align_set_o} !== {3'b110, cur_off})
        $display("FAIL range_reject%0d: got err/rdy/rst=%b%b%b set=%h want 110 %h",
                 k, cfg_err_o, ready_o, align_rst_o, align_set_o, cur_off);
      else pass_cnt++;
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk_cnt++;
      if (cfg_err_o !== 1'b0) $display("FAIL range_clr%0d: got %b want 0", k, cfg_err_o);
      else pass_cnt++;
    end
    for (int k = 0; k < 2; k++) begin
      apply_cfg(good[k]);
      cur_off = good[k];
      chk_cnt++;
      if ({cfg_err_o, align_rst_o, align_set_o} !== {2'b01, good[k]})
        $display("FAIL range_accept%0d: got err/rst=%b%b set=%h want 01 %h",
                 k, cfg_err_o, align_rst_o, align_set_o, good[k]);
      else pass_cnt++;
      realign("range_accept");
    end
    exp_cfg_err = 1'b0;
  endtask

  task automatic test_req_drop();
    for (int i = 0; i < MAX_N; i++) begin
      en_pat[i]  = (i < 37);
      req_pat[i] = (i < 37);
    end
    run_scan(0, 200, 10, 1'b0, "drop37");
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    exp_cfg_err = 1'b0;
  endtask

  task automatic test_timeout();
    fill_pattern(0, MAX_N);
    run_scan(0, 200, -1, 1'b0, "timeout");
    // Clearing in the same cycle as a new rejected write: the new error stays set.
    err_clr_i = 1'b1;
    apply_cfg(32'hFFFF_E000);
    err_clr_i = 1'b0;
    chk_cnt++;
    if ({cfg_err_o, timeout_err_o} !== 2'b10)
      $display("FAIL clr_vs_err: got cfg/to=%b%b want 10", cfg_err_o, timeout_err_o);
    else pass_cnt++;
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk_cnt++;
    if ({cfg_err_o, timeout_err_o} !== 2'b00)
      $display("FAIL clr_all: got cfg/to=%b%b want 00", cfg_err_o, timeout_err_o);
    else pass_cnt++;
    exp_cfg_err = 1'b0; exp_to_err = 1'b0;
  endtask

  task automatic test_random();
    int v;
    bit legal;
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 16383));
        1:       v = -int'($urandom_range(1, FIFO_DEPTH - 1));
        2:       v = int'($urandom_range(16384, 32'h7FFF_FFFF));
        default: v = -FIFO_DEPTH - int'($urandom_range(0, 100000));
      endcase
      legal = (v >= 0 && v <= 16383) || (v < 0 && v > -FIFO_DEPTH);
      apply_cfg(32'(v));
      if (legal) begin
        cur_off = 32'(v);
        chk_cnt++;
        if ({align_rst_o, align_set_o} !== {1'b1, cur_off})
          $display("FAIL rnd_cfg_ok: got rst=%b set=%h want 1 %h", align_rst_o, align_set_o, cur_off);
        else pass_cnt++;
        realign("rnd_cfg");
      end else begin
        chk_cnt++;
        if ({cfg_err_o, ready_o, align_set_o} !== {2'b11, cur_off})
          $display("FAIL rnd_cfg_bad: got err/rdy=%b%b set=%h want 11 %h",
                   cfg_err_o, ready_o, align_set_o, cur_off);
        else pass_cnt++;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
      end
      fill_pattern($urandom_range(30, 100), $urandom_range(5, 150));
      run_scan($urandom_range(0, 60), 200, -1, 1'b0, "rnd_scan");
    end
  endtask

  task automatic test_async_reset();
    scan_len_i = 32'd0; scan_req_i = 1'b1; encode_en_i = 1'b1;
    repeat (6) tick();
    #3;
    rst_n_i = 1'b0;
    #1;
    chk_cnt++;
    if ({align_rst_o, align_set_o, scan_en_o, ready_o, busy_o, done_o, stop_reason_o,
         sample_cnt_o, cfg_err_o, timeout_err_o} !== 73'd0)
      $display("FAIL async_reset: got set=%h cnt=%0d en=%b busy=%b want all 0",
               align_set_o, sample_cnt_o, scan_en_o, busy_o);
    else pass_cnt++;
    repeat (2) tick();
    rst_n_i = 1'b1;
    cur_off = '0;
    repeat (4) tick();
    chk_cnt++;
    if ({ready_o, busy_o, scan_en_o, align_rst_o, sample_cnt_o} !== 36'd0)
      $display("FAIL async_idle: got rdy/busy/en/rst=%b%b%b%b cnt=%0d want 0000 0",
               ready_o, busy_o, scan_en_o, align_rst_o, sample_cnt_o);
    else pass_cnt++;
    apply_cfg(32'd100);
    cur_off = 32'd100;
    realign("async_recfg");
    repeat (5) tick();
    chk_cnt++;
    if ({ready_o, scan_en_o} !== 2'b10)
      $display("FAIL async_held_req: got rdy/en=%b%b want 10", ready_o, scan_en_o);
    else pass_cnt++;
    scan_req_i = 1'b0; encode_en_i = 1'b0;
    tick();
    fill_pattern(100, 20);
    run_scan(0, 200, -1, 1'b0, "async_fresh");
  endtask

  initial begin
    test_reset();
    test_cfg_offset();
    test_scan_length();
    test_offset_range();
    test_req_drop();
    test_timeout();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
